// File: rtl/final_fpga_cpu_oci_dct_packer.sv
// final_fpga_cpu_oci_dct_packer
// Packs 2-bit OCI debug-capture trace atoms into 30-bit capture words (15 atoms)
// and hands full or flushed words to the trace store over valid/ready.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   atom_valid/_data    : trace atom input; atom_ready is combinational
//   test_ending         : flush request (level, honoured only while running)
//   out_valid/_data/_count, out_ready : capture word output handshake
//   dct_buffer/dct_count: live packing buffer and its atom count
//   test_has_ended      : sticky, set once the flush has drained
module final_fpga_cpu_oci_dct_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        atom_valid,
  input  logic [1:0]  atom_data,
  output logic        atom_ready,
  input  logic        test_ending,
  output logic        out_valid,
  output logic [29:0] out_data,
  output logic [3:0]  out_count,
  input  logic        out_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        test_has_ended
);

  localparam int unsigned ATOM_W    = 2;
  localparam int unsigned NUM_ATOMS = 15;
  localparam int unsigned BUF_W     = ATOM_W * NUM_ATOMS;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ENDED = 2'd3
  } state_t;

  state_t             state_q;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BUF_W-1:0]   out_data_q;
  logic [CNT_W-1:0]   out_count_q;
  logic               out_valid_q;
  logic               ended_q;

  logic               slot_free;
  logic               full;
  logic               accept;
  logic               transfer;

  // Handshake decode and next packing buffer.
  always_comb begin
    slot_free  = !out_valid_q || out_ready;
    full       = (cnt_q == CNT_W'(NUM_ATOMS));
    atom_ready = (state_q == ST_RUN) && (!full || slot_free);
    accept     = atom_valid && atom_ready;
    transfer   = slot_free && (full || ((state_q == ST_FLUSH) && (cnt_q != '0)));

    buf_d = buf_q;
    cnt_d = cnt_q;
    if (transfer) begin
      buf_d = '0;
      cnt_d = '0;
    end
    // Uses the post-transfer count so a same-cycle atom lands in slot 0.
    if (accept) begin
      for (int unsigned i = 0; i < NUM_ATOMS; i++) begin
        if (CNT_W'(i) == cnt_d) begin
          buf_d[i*ATOM_W +: ATOM_W] = atom_data;
        end
      end
      cnt_d = cnt_d + CNT_W'(1);
    end
  end

  // State, buffer and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      buf_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
      ended_q     <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;

      if (transfer) begin
        out_data_q  <= buf_q;
        out_count_q <= cnt_q;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        ST_RUN: begin
          if (test_ending) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // Non-empty buffer leaves only once its transfer has fired.
          if ((cnt_q == '0) || slot_free) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!out_valid_q) begin
            state_q <= ST_ENDED;
            ended_q <= 1'b1;
          end
        end
        ST_ENDED: begin
          state_q <= ST_ENDED;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_count      = out_count_q;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign test_has_ended = ended_q;

endmodule

// File: tb/tb_final_fpga_cpu_oci_dct_packer.sv
// Directed self-checking bench for final_fpga_cpu_oci_dct_packer.
// Inputs change at the falling edge; outputs are sampled 1 ns later.
module tb_final_fpga_cpu_oci_dct_packer;

  logic        clk;
  logic        reset_n;
  logic        atom_valid;
  logic [1:0]  atom_data;
  logic        atom_ready;
  logic        test_ending;
  logic        out_valid;
  logic [29:0] out_data;
  logic [3:0]  out_count;
  logic        out_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;

  int pass_cnt;
  int total_cnt;

  final_fpga_cpu_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .atom_valid     (atom_valid),
    .atom_data      (atom_data),
    .atom_ready     (atom_ready),
    .test_ending    (test_ending),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_count      (out_count),
    .out_ready      (out_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_has_ended (test_has_ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one rising edge; leaves time at falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  // Synchronous reset for two edges, then release with idle inputs.
  task automatic do_reset();
    reset_n = 1'b0; atom_valid = 1'b0; atom_data = 2'b00;
    test_ending = 1'b0; out_ready = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    logic ar_ok;
    int   idx;
    logic acc;
    pass_cnt = 0; total_cnt = 0;

    // ---------------- reset values ----------------
    do_reset();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_dct_buffer", 32'(dct_buffer), 32'd0);
    chk("rst_dct_count", 32'(dct_count), 32'd0);
    chk("rst_ended", 32'(test_has_ended), 32'd0);
    chk("rst_atom_ready", 32'(atom_ready), 32'd1);

    // ---------------- streaming 16 atoms of 01 ----------------
    atom_valid = 1'b1; atom_data = 2'b01; out_ready = 1'b1;
    ar_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (!atom_ready) ar_ok = 1'b0;
      cyc();
    end
    atom_valid = 1'b0;
    #1;
    chk("stream_ready_never_drops", 32'(ar_ok), 32'd1);
    chk("stream_out_valid", 32'(out_valid), 32'd1);
    chk("stream_out_data", 32'(out_data), 32'h1555_5555);
    chk("stream_out_count", 32'(out_count), 32'd15);
    chk("stream_16th_count", 32'(dct_count), 32'd1);
    chk("stream_16th_slot0", 32'(dct_buffer), 32'h0000_0001);
    cyc(); #1;
    chk("stream_consumed", 32'(out_valid), 32'd0);

    // ---------------- backpressure, 31 atoms ----------------
    do_reset();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 35; c++) begin
      atom_valid = (idx < 31);
      atom_data  = 2'(idx % 4);
      #1;
      acc = atom_valid && atom_ready;
      cyc();
      if (acc) idx++;
    end
    #1;
    chk("bp_accepted", 32'(idx), 32'd30);
    chk("bp_atom_ready_low", 32'(atom_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_word1_held", 32'(out_data), 32'h24E4_E4E4);
    chk("bp_word1_count", 32'(out_count), 32'd15);
    chk("bp_buf_full_count", 32'(dct_count), 32'd15);
    chk("bp_buf_full_data", 32'(dct_buffer), 32'h1393_9393);
    out_ready = 1'b1;
    atom_data = 2'(idx % 4);
    #1;
    chk("bp_release_ready", 32'(atom_ready), 32'd1);
    cyc();
    atom_valid = 1'b0;
    #1;
    chk("bp_word2_valid", 32'(out_valid), 32'd1);
    chk("bp_word2_data", 32'(out_data), 32'h1393_9393);
    chk("bp_word2_count", 32'(out_count), 32'd15);
    chk("bp_atom31_count", 32'(dct_count), 32'd1);
    chk("bp_atom31_data", 32'(dct_buffer), 32'h0000_0002);
    cyc(); #1;
    chk("bp_word2_consumed", 32'(out_valid), 32'd0);

    // ---------------- partial flush of 5 atoms of 11 ----------------
    do_reset();
    out_ready = 1'b1; atom_valid = 1'b1; atom_data = 2'b11;
    repeat (5) cyc();
    atom_valid = 1'b0; test_ending = 1'b1;
    #1;
    chk("pf_buf_before", 32'(dct_buffer), 32'h0000_03FF);
    cyc();
    test_ending = 1'b0;
    atom_valid = 1'b1;
    #1;
    chk("pf_flush_ready_low", 32'(atom_ready), 32'd0);
    cyc();
    atom_valid = 1'b0;
    #1;
    chk("pf_out_valid", 32'(out_valid), 32'd1);
    chk("pf_out_data", 32'(out_data), 32'h0000_03FF);
    chk("pf_out_count", 32'(out_count), 32'd5);
    chk("pf_dct_count_cleared", 32'(dct_count), 32'd0);
    chk("pf_not_ended_yet", 32'(test_has_ended), 32'd0);
    cyc(); #1;
    chk("pf_consumed", 32'(out_valid), 32'd0);
    chk("pf_still_draining", 32'(test_has_ended), 32'd0);
    cyc(); #1;
    chk("pf_ended", 32'(test_has_ended), 32'd1);
    atom_valid = 1'b1; test_ending = 1'b1;
    #1;
    chk("pf_ended_ready_low", 32'(atom_ready), 32'd0);
    repeat (4) cyc();
    #1;
    chk("pf_ended_sticky", 32'(test_has_ended), 32'd1);
    chk("pf_ended_no_atoms", 32'(dct_count), 32'd0);
    chk("pf_ended_no_word", 32'(out_valid), 32'd0);
    atom_valid = 1'b0; test_ending = 1'b0;

    // ---------------- empty flush ----------------
    do_reset();
    out_ready = 1'b1; test_ending = 1'b1;
    cyc();                       // edge N: FLUSH
    test_ending = 1'b0;
    cyc(); #1;                   // edge N+1: DRAIN
    chk("ef_no_word", 32'(out_valid), 32'd0);
    chk("ef_not_ended_n1", 32'(test_has_ended), 32'd0);
    cyc(); #1;                   // edge N+2: ENDED
    chk("ef_ended_n2", 32'(test_has_ended), 32'd1);
    chk("ef_still_no_word", 32'(out_valid), 32'd0);

    // ---------------- flush on same cycle as 15th atom ----------------
    do_reset();
    out_ready = 1'b1; atom_valid = 1'b1; atom_data = 2'b01;
    repeat (14) cyc();
    atom_data = 2'b10; test_ending = 1'b1;
    cyc();
    atom_valid = 1'b0; test_ending = 1'b0;
    #1;
    chk("f15_count_full", 32'(dct_count), 32'd15);
    cyc(); #1;
    chk("f15_out_valid", 32'(out_valid), 32'd1);
    chk("f15_out_count", 32'(out_count), 32'd15);
    chk("f15_out_data", 32'(out_data), 32'h2555_5555);
    cyc(); cyc(); #1;
    chk("f15_ended", 32'(test_has_ended), 32'd1);

    // ---------------- reset during FLUSH with a word pending ----------------
    do_reset();
    out_ready = 1'b0; atom_valid = 1'b1; atom_data = 2'b01;
    repeat (17) cyc();           // word loaded at edge 16, two more atoms packed
    atom_valid = 1'b0; test_ending = 1'b1;
    cyc();
    test_ending = 1'b0;
    cyc(); #1;
    chk("rf_held_in_flush", 32'(out_valid), 32'd1);
    chk("rf_flush_count", 32'(dct_count), 32'd2);
    chk("rf_flush_ready_low", 32'(atom_ready), 32'd0);
    reset_n = 1'b0;
    cyc(); #1;
    chk("rf_out_valid", 32'(out_valid), 32'd0);
    chk("rf_out_data", 32'(out_data), 32'd0);
    chk("rf_out_count", 32'(out_count), 32'd0);
    chk("rf_dct_count", 32'(dct_count), 32'd0);
    chk("rf_dct_buffer", 32'(dct_buffer), 32'd0);
    chk("rf_ended", 32'(test_has_ended), 32'd0);
    chk("rf_run_ready", 32'(atom_ready), 32'd1);
    reset_n = 1'b1; atom_valid = 1'b1; atom_data = 2'b11;
    cyc();
    atom_valid = 1'b0;
    #1;
    chk("rf_restart_slot0", 32'(dct_buffer), 32'h0000_0003);
    chk("rf_restart_count", 32'(dct_count), 32'd1);
    chk("rf_restart_no_word", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/final_fpga_cpu_oci_dct_packer.md
# final_fpga_cpu_oci_dct_packer

Packs 2-bit debug-capture trace atoms from the CPU OCI into 30-bit capture words with a 4-bit fill count. Full or flushed words go to the trace-store side over a valid/ready handshake. The block sits between the OCI trace atom source and the trace store. It also drives the live `dct_buffer`/`dct_count` and the end-of-test handshake (`test_ending` → `test_has_ended`) monitored by the OCI test bench.

## Interface

- `ATOM_W`, 2, bits per trace atom (fixed; other values unsupported)
- `NUM_ATOMS`, 15, atoms per capture word; buffer width = `ATOM_W*NUM_ATOMS` = 30

- `clk`  in  1  single clock; all logic on its rising edge
- `reset_n`  in  1  reset is synchronous and active-low
- `atom_valid`  in  1  trace atom offered
- `atom_data`  in  2  trace atom payload
- `atom_ready`  out  1  atom accepted on a cycle where `atom_valid && atom_ready`
- `test_ending`  in  1  flush request, level-sampled; ignored unless state is RUN
- `out_valid`  out  1  capture word available
- `out_data`  out  30  packed capture word
- `out_count`  out  4  number of valid atoms in `out_data` (1..15)
- `out_ready`  in  1  consumer takes word on `out_valid && out_ready`
- `dct_buffer`  out  30  live packing buffer
- `dct_count`  out  4  live atom count in `dct_buffer` (0..15)
- `test_has_ended`  out  1  sticky: flush complete and output drained

## Operation

- Reset (`reset_n`=0 at an edge): state=RUN, `dct_buffer`=0, `dct_count`=0, `out_valid`=0, `out_data`=0, `out_count`=0, `test_has_ended`=0. Reset mid-word or mid-flush discards all contents. No partial word is emitted.
- Packing: an accepted atom is written to `dct_buffer[2k+1:2k]`, where k=`dct_count`, then `dct_count`++. Bit positions above the current count stay 0.
- `slot_free` = `!out_valid || out_ready`.
- Transfer: fires when registered `dct_count`==15 (or a flush condition holds) and `slot_free`. Effects:
  - `out_data`<=`dct_buffer`, `out_count`<=`dct_count`, `out_valid`<=1.
  - `dct_buffer`<=0, `dct_count`<=0.
  - If an atom is accepted in the same cycle, it lands at slot 0 and `dct_count`<=1.
- `out_valid` clears when the word is consumed and no new transfer happens in that cycle.
- `atom_ready` = (state==RUN) && (`dct_count`<15 || `slot_free`). It is combinational from registers and `out_ready`.
- States:
  - RUN: normal packing. `test_ending`=1 → FLUSH. An atom accepted in the same cycle is kept.
  - FLUSH: `atom_ready`=0. If `dct_count`>0 and `slot_free`, transfer the partial word → DRAIN. If `dct_count`==0 → DRAIN immediately. Otherwise stay in FLUSH.
  - DRAIN: wait until `out_valid`==0 (registered), then → ENDED.
  - ENDED: `test_has_ended`=1, `atom_ready`=0. Stays here until reset. Further `test_ending` is ignored.
- Atoms are never dropped, and `out_count` is never 0 while `out_valid`=1.

## Timing

- The 15th atom accepted at edge N gives `dct_count`=15 after N. If `slot_free`, the word is registered at edge N+1, so `out_valid`=1 in the cycle after N+1.
- Streaming with `out_ready`=1 sustains 1 atom/cycle with no bubbles: `atom_ready` stays 1 while `dct_count`==15.
- With `dct_count`==15 and `out_valid && !out_ready`: `atom_ready`=0, and buffer and output both hold.
- Flush with empty output: `test_ending` sampled at edge N gives FLUSH after N. The transfer happens at N+1 (DRAIN), consumption at ≥N+2, and ENDED/`test_has_ended`=1 one edge after `out_valid` falls.
- Flush with `dct_count`=0 and `out_valid`=0: `test_has_ended`=1 after edge N+2.
- Simultaneous consume and transfer: the old word leaves and the new word loads in the same edge, so `out_valid` stays 1.

## Test plan

- Reset, then 15 atoms `2'b01` back-to-back with `out_ready`=1 → one word, `out_data`=30'h1555_5555, `out_count`=15. `atom_ready` never drops, and the 16th atom appears at `dct_buffer[1:0]`.
- `out_ready`=0, offer 31 atoms → first word held, second buffer fills to 15, `atom_ready`=0 with the 31st atom pending. Set `out_ready`=1 → two words emitted in order, 31st atom accepted.
- 5 atoms `2'b11`, then pulse `test_ending` → `out_data`=30'h0000_03FF, `out_count`=5. After consumption, `test_has_ended`=1 and `atom_ready`=0 forever.
- `test_ending` with empty buffer and no output pending → no word emitted, `test_has_ended`=1 two edges after the sampling edge.
- `test_ending` asserted in the same cycle as an accepted atom at `dct_count`=14 → flush emits `out_count`=15 with that atom included.
- `reset_n`=0 during FLUSH with `out_valid`=1 → next cycle all outputs 0, state RUN, and packing restarts at slot 0.
